ps2_kbd_ctrl: RTL and testbench

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

---
 rtl/ps2_kbd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_kbd_ctrl                                                 |
// | Description : PS/2 keyboard scan-code decoder. Collects 0xE0 / 0xF0        |
// |               prefix bytes from the receiver and presents one key event    |
// |               (code + extended + break flags), held until acknowledged.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in   system clock, rising edge                               |
// |   reset        in   synchronous active-high reset                          |
// |   rx_done_tick in   one-cycle frame-complete pulse from the receiver       |
// |   rx_frame     in   [0] start, [8:1] data, [9] parity, [10] stop           |
// |   rx_en        out  receiver enable (low while an event is held)           |
// |   key_code     out  scan code of the held event                            |
// |   key_ext      out  event was preceded by 0xE0                             |
// |   key_break    out  event was preceded by 0xF0                             |
// |   key_valid    out  event pending until key_ack                            |
// |   key_ack      in   consumer acknowledge (ignored while key_valid=0)       |
// |   overrun      out  pulse: frame dropped while an event was held           |
// |   frame_err    out  pulse: frame rejected by the framing/parity check      |
// |   timeout      out  pulse: prefix not followed by a byte in time           |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   PS2_PARITY_CHECK_EN : when defined, frames with a bad start bit, stop    |
// |                         bit or parity are rejected. Otherwise every frame  |
// |                         is accepted and frame_err is tied low.             |
// +----------------------------------------------------------------------------+

module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [10:0] rx_frame,
  output logic        rx_en,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_break,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overrun,
  output logic        frame_err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic [19:0] C_TO_LAST = 20'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  C_EXT     = 8'hE0;
  localparam logic [7:0]  C_BRK     = 8'hF0;

  state_e      state_q;
  logic        ext_f_q;
  logic        brk_f_q;
  logic [19:0] cnt_q;
  logic        rx_en_q;
  logic [7:0]  key_code_q;
  logic        key_ext_q;
  logic        key_break_q;
  logic        key_valid_q;
  logic        overrun_q;
  logic        timeout_q;

  logic [7:0]  rx_byte;
  assign rx_byte = rx_frame[8:1];

`ifdef PS2_PARITY_CHECK_EN
  logic frame_ok;
  logic frame_err_q;
  // Odd parity over data plus parity bit, correct start and stop levels.
  assign frame_ok  = ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1]);
  assign frame_err = frame_err_q;
`else
  logic unused_frame_bits;
  assign unused_frame_bits = &{1'b0, rx_frame[10:9], rx_frame[0]};
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ext_f_q     <= 1'b0;
      brk_f_q     <= 1'b0;
      cnt_q       <= '0;
      rx_en_q     <= 1'b1;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      // Status outputs are single-cycle pulses.
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      frame_err_q <= 1'b0;
`endif
      // Any received frame restarts the inter-byte timer, whatever the state.
      if (rx_done_tick) begin
        cnt_q <= '0;
      end

      case (state_q)
        ST_IDLE, ST_PREFIX: begin
          if (rx_done_tick) begin
`ifdef PS2_PARITY_CHECK_EN
            if (!frame_ok) begin
              frame_err_q <= 1'b1;
              ext_f_q     <= 1'b0;
              brk_f_q     <= 1'b0;
              state_q     <= ST_IDLE;
            end else
`endif
            if (rx_byte == C_EXT) begin
              ext_f_q <= 1'b1;
              state_q <= ST_PREFIX;
            end else if (rx_byte == C_BRK) begin
              brk_f_q <= 1'b1;
              state_q <= ST_PREFIX;
            end else begin
              key_code_q  <= rx_byte;
              key_ext_q   <= ext_f_q;
              key_break_q <= brk_f_q;
              key_valid_q <= 1'b1;
              ext_f_q     <= 1'b0;
              brk_f_q     <= 1'b0;
              rx_en_q     <= 1'b0;
              state_q     <= ST_HOLD;
            end
          end else if (state_q == ST_PREFIX) begin
            // A frame arriving on the expiry cycle wins (handled above).
            if (cnt_q == C_TO_LAST) begin
              timeout_q <= 1'b1;
              ext_f_q   <= 1'b0;
              brk_f_q   <= 1'b0;
              cnt_q     <= '0;
              state_q   <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 20'd1;
            end
          end
        end

        ST_HOLD: begin
          // The held event is frozen; any frame now is lost, even on the
          // acknowledge cycle.
          if (rx_done_tick) begin
            overrun_q <= 1'b1;
          end
          if (key_ack) begin
            key_valid_q <= 1'b0;
            rx_en_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_en     = rx_en_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_kbd_ctrl                                              |
// | Description : Self-checking bench for ps2_kbd_ctrl (TIMEOUT_CYC = 16).     |
// |               Inputs change on the falling edge; outputs are observed on   |
// |               the falling edge after the capturing rising edge.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_ps2_kbd_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done_tick = 1'b0;
  logic [10:0] rx_frame = '0;
  logic        rx_en;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_break;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        overrun;
  logic        frame_err;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  ps2_kbd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_frame     (rx_frame),
    .rx_en        (rx_en),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_valid    (key_valid),
    .key_ack      (key_ack),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Present one frame for one cycle; returns on the falling edge after capture.
  task automatic send_byte(input logic [7:0] d, input bit bad_par);
    logic par;
    par = (~^d) ^ bad_par;
    rx_frame     = {1'b1, par, d, 1'b0};
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rx_en !== 1'b1)     begin errors++; $display("FAIL reset_rx_en: got %b expected 1", rx_en); end
    checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", key_code); end
    checks++; if ({key_ext, key_break, key_valid} !== 3'b000) begin errors++; $display("FAIL reset_key_flags: got %b expected 000", {key_ext, key_break, key_valid}); end
    checks++; if ({overrun, frame_err, timeout} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {overrun, frame_err, timeout}); end
  endtask

  task automatic test_make();
    send_byte(8'h1C, 1'b0);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL make_valid: got %b expected 1", key_valid); end
    checks++; if ({key_code, key_ext, key_break} !== {8'h1C, 2'b00}) begin errors++; $display("FAIL make_event: got %h/%b%b expected 1c/00", key_code, key_ext, key_break); end
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL make_rx_en_hold: got %b expected 0", rx_en); end
    repeat (4) @(negedge clk);
    checks++; if ({rx_en, key_valid} !== 2'b01) begin errors++; $display("FAIL make_held: got rx_en/valid %b expected 01", {rx_en, key_valid}); end
    do_ack();
    checks++; if ({rx_en, key_valid} !== 2'b10) begin errors++; $display("FAIL make_after_ack: got rx_en/valid %b expected 10", {rx_en, key_valid}); end
  endtask

  task automatic test_ext_break();
    send_byte(8'hE0, 1'b0);
    checks++; if ({key_valid, rx_en} !== 2'b01) begin errors++; $display("FAIL prefix_e0: got valid/rx_en %b expected 01", {key_valid, rx_en}); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, 8'h74, 2'b11}) begin errors++; $display("FAIL ext_break_event: got %b/%h/%b%b expected 1/74/11", key_valid, key_code, key_ext, key_break); end
    do_ack();
    // Acknowledge while nothing is pending must not disturb a prefix.
    do_ack();
    send_byte(8'hE0, 1'b0);
    do_ack();
    checks++; if ({key_valid, rx_en} !== 2'b01) begin errors++; $display("FAIL stray_ack: got valid/rx_en %b expected 01", {key_valid, rx_en}); end
    send_byte(8'h75, 1'b0);
    checks++; if ({key_code, key_ext, key_break} !== {8'h75, 2'b10}) begin errors++; $display("FAIL stray_ack_event: got %h/%b%b expected 75/10", key_code, key_ext, key_break); end
    do_ack();
  endtask

  task automatic test_timeout();
    send_byte(8'hF0, 1'b0);
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      if (i == TO - 1) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", timeout); end
      end
      if (i == TO) begin
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", timeout); end
      end
      if (i == TO + 1) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b expected 0", timeout); end
      end
    end
    send_byte(8'h1C, 1'b0);
    checks++; if ({key_valid, key_code, key_break} !== {1'b1, 8'h1C, 1'b0}) begin errors++; $display("FAIL timeout_flags_cleared: got %b/%h/%b expected 1/1c/0", key_valid, key_code, key_break); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_byte(8'h1C, 1'b0);
    send_byte(8'h32, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
    checks++; if ({key_code, key_valid} !== {8'h1C, 1'b1}) begin errors++; $display("FAIL overrun_hold: got %h/%b expected 1c/1", key_code, key_valid); end
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b expected 0", overrun); end
    // Frame on the acknowledge cycle is also dropped.
    key_ack = 1'b1;
    send_byte(8'h33, 1'b0);
    key_ack = 1'b0;
    checks++; if ({overrun, key_valid, rx_en, key_code} !== {3'b101, 8'h1C}) begin errors++; $display("FAIL overrun_ack_cycle: got %b%b%b/%h expected 101/1c", overrun, key_valid, rx_en, key_code); end
  endtask

  task automatic test_frame_err();
    send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if ({frame_err, key_valid} !== 2'b10) begin errors++; $display("FAIL parity_reject: got err/valid %b expected 10", {frame_err, key_valid}); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h75, 1'b0);
    checks++; if ({key_valid, key_code, key_ext} !== {1'b1, 8'h75, 1'b0}) begin errors++; $display("FAIL parity_flags_cleared: got %b/%h/%b expected 1/75/0", key_valid, key_code, key_ext); end
    do_ack();
`else
    checks++; if ({frame_err, key_valid, key_code} !== {2'b01, 8'h1C}) begin errors++; $display("FAIL parity_ignored: got %b%b/%h expected 01/1c", frame_err, key_valid, key_code); end
    do_ack();
`endif
  endtask

  task automatic test_reset_mid();
    send_byte(8'hE0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({rx_en, key_valid, key_ext, key_break, overrun, frame_err, timeout} !== 7'b1000000) begin errors++; $display("FAIL reset_prefix: got %b expected 1000000", {rx_en, key_valid, key_ext, key_break, overrun, frame_err, timeout}); end
    send_byte(8'h75, 1'b0);
    checks++; if ({key_valid, key_code, key_ext} !== {1'b1, 8'h75, 1'b0}) begin errors++; $display("FAIL reset_prefix_event: got %b/%h/%b expected 1/75/0", key_valid, key_code, key_ext); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({rx_en, key_valid, key_code} !== {2'b10, 8'h00}) begin errors++; $display("FAIL reset_hold: got %b%b/%h expected 10/00", rx_en, key_valid, key_code); end
  endtask

  // Random byte streams. The model keeps the list of prefix bytes seen since
  // the last event; an event's flags are "E0 present" / "F0 present" in it.
  task automatic test_random();
    logic [7:0] pend[$];
    int         gaps[7] = '{0, 1, 2, 3, TO - 1, TO, TO + 4};
    int         g;
    int         seen_to;
    int         exp_to;
    logic [7:0] b;
    bit         e_ext;
    bit         e_brk;
    for (int n = 0; n < 150; n++) begin
      g = gaps[$urandom_range(0, 6)];
      exp_to = (pend.size() > 0 && g >= TO) ? 1 : 0;
      seen_to = 0;
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        if (timeout === 1'b1) seen_to++;
      end
      checks++; if (seen_to != exp_to) begin errors++; $display("FAIL rand_timeout: got %0d pulses expected %0d (gap %0d)", seen_to, exp_to, g); end
      if (exp_to == 1) pend.delete();
      case ($urandom_range(0, 3))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b, 1'b0);
      if (b == 8'hE0 || b == 8'hF0) begin
        pend.push_back(b);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rand_prefix_valid: got %b expected 0", key_valid); end
      end else begin
        e_ext = 1'b0;
        e_brk = 1'b0;
        foreach (pend[k]) begin
          if (pend[k] == 8'hE0) e_ext = 1'b1;
          if (pend[k] == 8'hF0) e_brk = 1'b1;
        end
        pend.delete();
        checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, b, e_ext, e_brk}) begin errors++; $display("FAIL rand_event: got %b/%h/%b%b expected 1/%h/%b%b", key_valid, key_code, key_ext, key_break, b, e_ext, e_brk); end
        if ($urandom_range(0, 3) == 0) begin
          send_byte(8'($urandom_range(0, 255)), 1'b0);
          checks++; if ({overrun, key_code} !== {1'b1, b}) begin errors++; $display("FAIL rand_overrun: got %b/%h expected 1/%h", overrun, key_code, b); end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_ack();
        checks++; if ({key_valid, rx_en} !== 2'b01) begin errors++; $display("FAIL rand_ack: got valid/rx_en %b expected 01", {key_valid, rx_en}); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_make();
    test_ext_break();
    test_timeout();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
